// File: rtl/descriptor_dispatch_scheduler.sv
// Dispatches corners to free descriptor units and re-serialises their results in dispatch order.
// Frame FSM: RUN | accepting corners ; DRAIN | no new corners, finish in-flight work, then pulse complete.
module descriptor_dispatch_scheduler #(
    parameter int PARALLEL_MODULES = 4,
    parameter int COORD_BITS       = 10,
    parameter int DESC_BITS        = 256
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_begin_frame_reset,
    output logic                                  out_frame_reset_complete,
    input  logic                                  in_feature_valid,
    input  logic [COORD_BITS-1:0]                 in_feature_x,
    input  logic [COORD_BITS-1:0]                 in_feature_y,
    output logic                                  out_feature_ready,
    output logic [PARALLEL_MODULES-1:0]           unit_start,
    output logic [COORD_BITS-1:0]                 unit_x,
    output logic [COORD_BITS-1:0]                 unit_y,
    input  logic [PARALLEL_MODULES-1:0]           unit_done,
    input  logic [PARALLEL_MODULES*DESC_BITS-1:0] unit_descriptor,
    output logic                                  out_valid,
    output logic [DESC_BITS-1:0]                  out_descriptor,
    output logic [COORD_BITS-1:0]                 out_feature_x,
    output logic [COORD_BITS-1:0]                 out_feature_y,
    output logic                                  out_protocol_error
);
    localparam int IDX_W = (PARALLEL_MODULES > 1) ? $clog2(PARALLEL_MODULES) : 1;
    localparam int CNT_W = $clog2(PARALLEL_MODULES + 1);

    typedef enum logic [1:0] {SLOT_IDLE, SLOT_BUSY, SLOT_DONE} slot_state_t;
    typedef enum logic {FRAME_RUN, FRAME_DRAIN} frame_state_t;

    slot_state_t           slot_state_q [PARALLEL_MODULES];
    logic [COORD_BITS-1:0] slot_x_q     [PARALLEL_MODULES];
    logic [COORD_BITS-1:0] slot_y_q     [PARALLEL_MODULES];
    logic [DESC_BITS-1:0]  slot_desc_q  [PARALLEL_MODULES];

    logic [IDX_W-1:0]      fifo_q [PARALLEL_MODULES];
    logic [IDX_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]      count_q;

    frame_state_t          frame_q;
    logic                  out_valid_q;
    logic [DESC_BITS-1:0]  out_desc_q;
    logic [COORD_BITS-1:0] out_x_q, out_y_q;
    logic                  complete_q;
    logic                  error_q;

    logic                  any_idle, all_idle;
    logic [IDX_W-1:0]      free_idx;
    logic [IDX_W-1:0]      head_idx;
    logic                  dispatch, release_head;

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(PARALLEL_MODULES - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    // Descending scan so the lowest-index idle slot wins.
    always_comb begin
        any_idle = 1'b0;
        all_idle = 1'b1;
        free_idx = '0;
        for (int k = PARALLEL_MODULES - 1; k >= 0; k--) begin
            if (slot_state_q[k] == SLOT_IDLE) begin
                any_idle = 1'b1;
                free_idx = IDX_W'(k);
            end else begin
                all_idle = 1'b0;
            end
        end
    end

    assign head_idx          = fifo_q[rd_ptr_q];
    assign release_head      = (count_q != '0) && (slot_state_q[head_idx] == SLOT_DONE);
    assign out_feature_ready = (frame_q == FRAME_RUN) && any_idle;
    assign dispatch          = in_feature_valid && out_feature_ready;

    assign unit_start = dispatch ? (PARALLEL_MODULES'(1) << free_idx) : '0;
    assign unit_x     = dispatch ? in_feature_x : '0;
    assign unit_y     = dispatch ? in_feature_y : '0;

    assign out_valid                = out_valid_q;
    assign out_descriptor           = out_desc_q;
    assign out_feature_x            = out_x_q;
    assign out_feature_y            = out_y_q;
    assign out_frame_reset_complete = complete_q;
    assign out_protocol_error       = error_q;

    // Completion, release and dispatch always touch distinct slots (BUSY, DONE, IDLE respectively).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < PARALLEL_MODULES; k++) begin
                slot_state_q[k] <= SLOT_IDLE;
                slot_x_q[k]     <= '0;
                slot_y_q[k]     <= '0;
                slot_desc_q[k]  <= '0;
                fifo_q[k]       <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            frame_q     <= FRAME_RUN;
            out_valid_q <= 1'b0;
            out_desc_q  <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            complete_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            for (int k = 0; k < PARALLEL_MODULES; k++) begin
                if (unit_done[k]) begin
                    if (slot_state_q[k] == SLOT_BUSY) begin
                        slot_state_q[k] <= SLOT_DONE;
                        slot_desc_q[k]  <= unit_descriptor[k*DESC_BITS +: DESC_BITS];
                    end else begin
                        error_q <= 1'b1;
                    end
                end
            end

            out_valid_q <= release_head;
            if (release_head) begin
                slot_state_q[head_idx] <= SLOT_IDLE;
                out_desc_q             <= slot_desc_q[head_idx];
                out_x_q                <= slot_x_q[head_idx];
                out_y_q                <= slot_y_q[head_idx];
                rd_ptr_q               <= ptr_inc(rd_ptr_q);
            end

            if (dispatch) begin
                slot_state_q[free_idx] <= SLOT_BUSY;
                slot_x_q[free_idx]     <= in_feature_x;
                slot_y_q[free_idx]     <= in_feature_y;
                fifo_q[wr_ptr_q]       <= free_idx;
                wr_ptr_q               <= ptr_inc(wr_ptr_q);
                if (!release_head && count_q == CNT_W'(PARALLEL_MODULES))
                    error_q <= 1'b1;
            end

            case ({dispatch, release_head})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            complete_q <= 1'b0;
            case (frame_q)
                FRAME_RUN: begin
                    if (in_begin_frame_reset)
                        frame_q <= FRAME_DRAIN;
                end
                FRAME_DRAIN: begin
                    if (all_idle && count_q == '0) begin
                        complete_q <= 1'b1;
                        frame_q    <= FRAME_RUN;
                    end
                end
                default: frame_q <= FRAME_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_descriptor_dispatch_scheduler.sv
// Directed bench: plays the descriptor units by hand and checks dispatch, ordering, drain and error behaviour.
module tb_descriptor_dispatch_scheduler;
    localparam int PM = 4;
    localparam int CB = 10;
    localparam int DB = 256;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_begin_frame_reset;
    logic            out_frame_reset_complete;
    logic            in_feature_valid;
    logic [CB-1:0]   in_feature_x, in_feature_y;
    logic            out_feature_ready;
    logic [PM-1:0]   unit_start;
    logic [CB-1:0]   unit_x, unit_y;
    logic [PM-1:0]   unit_done;
    logic [PM*DB-1:0] unit_descriptor;
    logic            out_valid;
    logic [DB-1:0]   out_descriptor;
    logic [CB-1:0]   out_feature_x, out_feature_y;
    logic            out_protocol_error;

    descriptor_dispatch_scheduler #(.PARALLEL_MODULES(PM), .COORD_BITS(CB), .DESC_BITS(DB)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .in_begin_frame_reset     (in_begin_frame_reset),
        .out_frame_reset_complete (out_frame_reset_complete),
        .in_feature_valid         (in_feature_valid),
        .in_feature_x             (in_feature_x),
        .in_feature_y             (in_feature_y),
        .out_feature_ready        (out_feature_ready),
        .unit_start               (unit_start),
        .unit_x                   (unit_x),
        .unit_y                   (unit_y),
        .unit_done                (unit_done),
        .unit_descriptor          (unit_descriptor),
        .out_valid                (out_valid),
        .out_descriptor           (out_descriptor),
        .out_feature_x            (out_feature_x),
        .out_feature_y            (out_feature_y),
        .out_protocol_error       (out_protocol_error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CB-1:0] x;
        logic [CB-1:0] y;
        logic [DB-1:0] d;
        int unsigned   c;
    } res_t;

    res_t        res_q[$];
    int unsigned cmp_q[$];

    always @(negedge clk) begin
        res_t r;
        if (out_valid) begin
            r.x = out_feature_x;
            r.y = out_feature_y;
            r.d = out_descriptor;
            r.c = cyc;
            res_q.push_back(r);
        end
        if (out_frame_reset_complete) cmp_q.push_back(cyc);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DB-1:0] desc_of(input logic [CB-1:0] x, input logic [CB-1:0] y);
        return {236'hF00D, x, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one feature for one cycle and checks it lands on the expected slot.
    task automatic dispatch(input logic [CB-1:0] x, input logic [CB-1:0] y, input int slot);
        in_feature_valid = 1'b1;
        in_feature_x     = x;
        in_feature_y     = y;
        #2;
        check_eq("disp_ready", out_feature_ready, 1'b1);
        check_eq("disp_start", unit_start, PM'(1) << slot);
        check_eq("disp_xy", {unit_x, unit_y}, {x, y});
        tick();
        in_feature_valid = 1'b0;
    endtask

    task automatic done(input int slot, input logic [CB-1:0] x, input logic [CB-1:0] y);
        unit_done       = PM'(1) << slot;
        unit_descriptor = '0;
        unit_descriptor[slot*DB +: DB] = desc_of(x, y);
        tick();
        unit_done = '0;
    endtask

    task automatic exp_out(input int i, input logic [CB-1:0] x, input logic [CB-1:0] y, input int unsigned c);
        if (i < res_q.size()) begin
            check_eq("out_xy", {res_q[i].x, res_q[i].y}, {x, y});
            check_eq("out_desc", res_q[i].d, desc_of(x, y));
            check_eq("out_cycle", res_q[i].c, c);
        end else begin
            check_eq("out_missing", res_q.size(), i + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int unsigned c0;
        reset                = 1'b1;
        in_begin_frame_reset = 1'b0;
        in_feature_valid     = 1'b0;
        in_feature_x         = '0;
        in_feature_y         = '0;
        unit_done            = '0;
        unit_descriptor      = '0;
        tick();
        tick();
        reset = 1'b0;
        #2;
        check_eq("rst_ready", out_feature_ready, 1'b1);
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_err", out_protocol_error, 1'b0);
        check_eq("rst_cmp", out_frame_reset_complete, 1'b0);
        check_eq("rst_start", unit_start, '0);
        check_eq("rst_data", {out_descriptor, out_feature_x, out_feature_y}, '0);
        tick();

        // Four back-to-back features, completed in order.
        dispatch(10, 2, 0);
        dispatch(20, 2, 1);
        dispatch(30, 2, 2);
        dispatch(5, 3, 3);
        #2;
        check_eq("t1_ready_full", out_feature_ready, 1'b0);
        repeat (18) tick();
        c0 = cyc;
        done(0, 10, 2);
        done(1, 20, 2);
        done(2, 30, 2);
        done(3, 5, 3);
        repeat (4) tick();
        check_eq("t1_count", res_q.size(), 4);
        exp_out(0, 10, 2, c0 + 2);
        exp_out(1, 20, 2, c0 + 3);
        exp_out(2, 30, 2, c0 + 4);
        exp_out(3, 5, 3, c0 + 5);
        res_q.delete();

        // Out-of-order completion is re-serialised.
        dispatch(100, 7, 0);
        dispatch(200, 8, 1);
        repeat (3) tick();
        done(1, 200, 8);
        repeat (6) tick();
        c0 = cyc;
        done(0, 100, 7);
        repeat (4) tick();
        check_eq("t2_count", res_q.size(), 2);
        exp_out(0, 100, 7, c0 + 2);
        exp_out(1, 200, 8, c0 + 3);
        res_q.delete();

        // Backpressure with all units busy and a fifth feature held.
        dispatch(1, 1, 0);
        dispatch(2, 1, 1);
        dispatch(3, 1, 2);
        dispatch(4, 1, 3);
        in_feature_valid = 1'b1;
        in_feature_x     = 9;
        in_feature_y     = 9;
        repeat (3) begin
            #2;
            check_eq("t3_hold_ready", out_feature_ready, 1'b0);
            check_eq("t3_hold_start", unit_start, '0);
            tick();
        end
        c0 = cyc;
        done(0, 1, 1);
        #2;
        check_eq("t3_ready_rel", out_feature_ready, 1'b0);
        tick();
        #2;
        check_eq("t3_ready_after", out_feature_ready, 1'b1);
        check_eq("t3_start_after", unit_start, 4'b0001);
        tick();
        in_feature_valid = 1'b0;
        done(1, 2, 1);
        done(2, 3, 1);
        done(3, 4, 1);
        done(0, 9, 9);
        repeat (4) tick();
        check_eq("t3_count", res_q.size(), 5);
        exp_out(0, 1, 1, c0 + 2);
        exp_out(1, 2, 1, c0 + 5);
        exp_out(2, 3, 1, c0 + 6);
        exp_out(3, 4, 1, c0 + 7);
        exp_out(4, 9, 9, c0 + 8);
        res_q.delete();

        // Drain with three units busy.
        dispatch(11, 4, 0);
        dispatch(12, 4, 1);
        dispatch(13, 4, 2);
        in_begin_frame_reset = 1'b1;
        tick();
        in_begin_frame_reset = 1'b0;
        #2;
        check_eq("t4_ready_drain", out_feature_ready, 1'b0);
        tick();
        in_begin_frame_reset = 1'b1;
        tick();
        in_begin_frame_reset = 1'b0;
        done(0, 11, 4);
        done(1, 12, 4);
        c0 = cyc;
        done(2, 13, 4);
        #2;
        check_eq("t4_ready_c1", out_feature_ready, 1'b0);
        tick();
        #2;
        check_eq("t4_cmp_early", out_frame_reset_complete, 1'b0);
        tick();
        #2;
        check_eq("t4_cmp_pulse", out_frame_reset_complete, 1'b1);
        check_eq("t4_ready_back", out_feature_ready, 1'b1);
        repeat (3) tick();
        check_eq("t4_cmp_count", cmp_q.size(), 1);
        if (cmp_q.size() > 0) check_eq("t4_cmp_cycle", cmp_q[0], c0 + 3);
        check_eq("t4_count", res_q.size(), 3);
        exp_out(0, 11, 4, c0);
        exp_out(1, 12, 4, c0 + 1);
        exp_out(2, 13, 4, c0 + 2);
        res_q.delete();
        cmp_q.delete();

        // Drain with nothing in flight completes two cycles after the request.
        c0 = cyc;
        in_begin_frame_reset = 1'b1;
        tick();
        in_begin_frame_reset = 1'b0;
        #2;
        check_eq("t4i_ready", out_feature_ready, 1'b0);
        repeat (3) tick();
        check_eq("t4i_cmp_count", cmp_q.size(), 1);
        if (cmp_q.size() > 0) check_eq("t4i_cmp_cycle", cmp_q[0], c0 + 2);
        cmp_q.delete();

        // Drain request coinciding with an accepted dispatch.
        in_feature_valid     = 1'b1;
        in_feature_x         = 50;
        in_feature_y         = 5;
        in_begin_frame_reset = 1'b1;
        #2;
        check_eq("t4c_start", unit_start, 4'b0001);
        tick();
        in_feature_valid     = 1'b0;
        in_begin_frame_reset = 1'b0;
        #2;
        check_eq("t4c_ready", out_feature_ready, 1'b0);
        tick();
        c0 = cyc;
        done(0, 50, 5);
        repeat (4) tick();
        check_eq("t4c_cmp_count", cmp_q.size(), 1);
        if (cmp_q.size() > 0) check_eq("t4c_cmp_cycle", cmp_q[0], c0 + 3);
        exp_out(0, 50, 5, c0 + 2);
        res_q.delete();
        cmp_q.delete();

        // Spurious completion on an idle slot.
        check_eq("t5_err_pre", out_protocol_error, 1'b0);
        unit_done       = 4'b0100;
        unit_descriptor = {PM{desc_of(7, 7)}};
        tick();
        unit_done = '0;
        #2;
        check_eq("t5_err_set", out_protocol_error, 1'b1);
        repeat (3) tick();
        check_eq("t5_err_sticky", out_protocol_error, 1'b1);
        check_eq("t5_no_out", res_q.size(), 0);

        // Reset with two units busy, then a late completion.
        dispatch(60, 6, 0);
        dispatch(70, 6, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        check_eq("t6_ready", out_feature_ready, 1'b1);
        check_eq("t6_valid", out_valid, 1'b0);
        check_eq("t6_err", out_protocol_error, 1'b0);
        check_eq("t6_cmp", out_frame_reset_complete, 1'b0);
        tick();
        dispatch(80, 8, 0);
        done(1, 70, 6);
        #2;
        check_eq("t6_late_err", out_protocol_error, 1'b1);
        repeat (3) tick();
        check_eq("t6_no_out", res_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/descriptor_dispatch_scheduler.md
Name: descriptor_dispatch_scheduler

Overview:
- Sits between the nonmax/threshold corner stage and the PARALLEL_MODULES descriptor units inside the buffered corners-and-descriptors pipeline.
- Assigns each accepted corner to a free descriptor unit and stalls upstream when every unit is occupied.
- Captures unit results and re-serialises them in dispatch (raster) order onto a single output stream.
- Sequences frame-boundary draining via the begin-frame-reset / reset-complete handshake.

Parameters:
PARALLEL_MODULES, 4, number of descriptor units scheduled (2..16)
COORD_BITS, 10, width of feature x/y coordinates
DESC_BITS, 256, descriptor width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_begin_frame_reset  in  1  request drain before new frame (1-cycle pulse)
out_frame_reset_complete  out  1  1-cycle pulse: drain finished
in_feature_valid  in  1  corner available
in_feature_x  in  COORD_BITS  corner x
in_feature_y  in  COORD_BITS  corner y
out_feature_ready  out  1  corner accepted when valid&&ready
unit_start  out  PARALLEL_MODULES  one-hot, 1-cycle start pulse to unit k
unit_x  out  COORD_BITS  coordinate broadcast to units, valid with unit_start
unit_y  out  COORD_BITS  as unit_x
unit_done  in  PARALLEL_MODULES  1-cycle completion pulse from unit k
unit_descriptor  in  PARALLEL_MODULES*DESC_BITS  unit k result at bits [k*DESC_BITS +: DESC_BITS], valid with unit_done[k]
out_valid  out  1  result pulse (no backpressure)
out_descriptor  out  DESC_BITS  result descriptor
out_feature_x  out  COORD_BITS  result x
out_feature_y  out  COORD_BITS  result y
out_protocol_error  out  1  sticky: unit_done on non-BUSY slot or order-FIFO overflow

Behaviour:
- Reset:
  - All slots IDLE; order FIFO empty; FSM in RUN.
  - out_valid, out_frame_reset_complete, out_protocol_error, unit_start = 0; data outputs = 0.
  - out_feature_ready = 1 from the first cycle after reset.
  - reset mid-operation discards all in-flight work; late unit_done pulses arriving after reset set out_protocol_error.
- Per-slot state {IDLE, BUSY, DONE} with registered x, y and descriptor.
- Order FIFO, depth PARALLEL_MODULES, holds slot indices in dispatch order.
- out_feature_ready = (FSM == RUN) && any slot IDLE. Combinational from registered state only; never from in_feature_valid.
- Dispatch, on valid && ready:
  - Choose the lowest-index IDLE slot k.
  - Drive unit_start[k] = 1 and unit_x/unit_y = input coordinates combinationally in the same cycle.
  - Slot k becomes BUSY at the clock edge; coordinates are latched; k is pushed to the FIFO.
  - unit_start is 0 in all other cycles.
- Completion: unit_done[k] with slot k BUSY latches the descriptor and moves the slot to DONE. unit_done[k] with slot k not BUSY is ignored and sets out_protocol_error.
- Release:
  - If the FIFO head slot h is DONE, pop the FIFO and set slot h to IDLE.
  - Next cycle: out_valid = 1 with slot h's descriptor and coordinates. Latency from the DONE state to out_valid is 1 cycle.
  - At most one release per cycle.
- A done slot behind a BUSY head waits; results are never reordered.
- Same-cycle events:
  - Dispatch, completion and release may all occur in one cycle.
  - A slot released in cycle t is dispatchable from cycle t+1 (ready uses registered state).
  - unit_done on the head slot in cycle t gives release in cycle t+1 and out_valid in cycle t+2.
- Frame FSM {RUN, DRAIN}:
  - in_begin_frame_reset in RUN goes to DRAIN. Ready = 0 in DRAIN; completion and release continue.
  - In DRAIN, with all slots IDLE and the FIFO empty, out_frame_reset_complete pulses 1 cycle and the FSM returns to RUN.
  - in_begin_frame_reset with nothing in flight: complete pulses the cycle after DRAIN is entered (2 cycles after the request).
  - in_begin_frame_reset while already in DRAIN is ignored.
  - in_begin_frame_reset coinciding with an accepted dispatch: the dispatch completes and that unit is drained too.

Test Plan:
- Reset, then 4 features (10,2), (20,2), (30,2), (5,3) back-to-back, with units done in order 20 cycles later -> unit_start 0001, 0010, 0100, 1000 on consecutive cycles; ready drops after the 4th; out_valid emits the 4 results in input order, each 1 cycle after its slot's release.
- 2 in flight, unit 1 done at cycle 5, unit 0 done at cycle 12 -> no out_valid until cycle 14; (x0,y0) at cycle 14, (x1,y1) at cycle 15.
- All 4 busy, upstream valid held -> ready = 0 until the head releases; the 5th feature goes to slot 0 the cycle after release; no feature lost or duplicated.
- in_begin_frame_reset with 3 units busy -> ready = 0; the 3 results are emitted; out_frame_reset_complete pulses once, 1 cycle after the last slot goes IDLE; ready returns to 1.
- Spurious unit_done[2] with slot 2 IDLE -> out_protocol_error = 1 and stays set; no out_valid generated.
- Reset asserted with 2 units busy -> next cycle all outputs at reset values and ready = 1; subsequent dispatch uses slot 0.
